// File: rtl/bin_to_bcd_seq_if.sv
// Start/result handshake between a display controller and the BCD converter.
// The master drives start/bin_in; the slave returns busy/done and the held result.
interface bin_to_bcd_seq_if #(
  parameter int BIN_W  = 20,
  parameter int DIGITS = 6
);
  logic                  start;
  logic [BIN_W-1:0]      bin_in;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd_out;
  logic [DIGITS-1:0]     blank;
  logic                  overflow;

  modport master (
    output start, bin_in,
    input  busy, done, bcd_out, blank, overflow
  );

  modport slave (
    input  start, bin_in,
    output busy, done, bcd_out, blank, overflow
  );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter, one input bit per clock, feeding the
// HEX digit decoders with registered digits, a leading-zero blank mask and overflow.
//
// state | meaning
// IDLE  | waiting for start; last result held on the outputs
// SHIFT | one add-3/shift iteration per clock, r_cnt counts down to 1
module bin_to_bcd_seq #(
  parameter int BIN_W  = 20,
  parameter int DIGITS = 6
) (
  input  logic              clk,
  input  logic              rst,
  bin_to_bcd_seq_if.slave   bus
);
  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t             r_state;
  logic [BIN_W-1:0]   r_shift;
  logic [BCD_W-1:0]   r_scratch;
  logic               r_ovf_sticky;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_busy;
  logic               r_done;
  logic [BCD_W-1:0]   r_bcd;
  logic [DIGITS-1:0]  r_blank;
  logic               r_overflow;

  logic [BCD_W-1:0]   w_adj;
  logic [BCD_W-1:0]   w_next_scratch;
  logic [BIN_W-1:0]   w_next_shift;
  logic               w_ovf_next;

  // Leading-zero mask: a digit blanks only while it and every higher digit are zero.
  function automatic logic [DIGITS-1:0] f_blank(input logic [BCD_W-1:0] d);
    logic run;
    f_blank = '0;
    run     = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      run        = run & (d[4*i +: 4] == 4'd0);
      f_blank[i] = run;
    end
  endfunction

  always_comb begin
    w_adj = r_scratch;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_scratch[4*i +: 4] >= 4'd5) begin
        w_adj[4*i +: 4] = r_scratch[4*i +: 4] + 4'd3;
      end
    end
  end

  // A bit leaving the top digit means the value no longer fits in DIGITS digits.
  assign w_next_scratch = {w_adj[BCD_W-2:0], r_shift[BIN_W-1]};
  assign w_next_shift   = {r_shift[BIN_W-2:0], 1'b0};
  assign w_ovf_next     = r_ovf_sticky | w_adj[BCD_W-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_shift      <= '0;
      r_scratch    <= '0;
      r_ovf_sticky <= 1'b0;
      r_cnt        <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_bcd        <= '0;
      r_blank      <= f_blank('0);
      r_overflow   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_shift      <= bus.bin_in;
            r_scratch    <= '0;
            r_ovf_sticky <= 1'b0;
            r_cnt        <= CNT_W'(BIN_W);
            r_busy       <= 1'b1;
            r_state      <= SHIFT;
          end
        end
        SHIFT: begin
          r_shift      <= w_next_shift;
          r_scratch    <= w_next_scratch;
          r_ovf_sticky <= w_ovf_next;
          r_cnt        <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
            r_overflow <= w_ovf_next;
            r_state    <= IDLE;
            if (w_ovf_next) begin
              r_bcd   <= {DIGITS{4'hE}};
              r_blank <= '0;
            end else begin
              r_bcd   <= w_next_scratch;
              r_blank <= f_blank(w_next_scratch);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.bcd_out  = r_bcd;
  assign bus.blank    = r_blank;
  assign bus.overflow = r_overflow;
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Randomized and directed bench for bin_to_bcd_seq; results are compared
// against an arithmetic decimal model (divide/modulo, powers of ten).
module tb_bin_to_bcd_seq;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bin_to_bcd_seq_if #(.BIN_W(20), .DIGITS(6)) bus ();
  bin_to_bcd_seq #(.BIN_W(20), .DIGITS(6)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void model(input int unsigned v, output logic [23:0] bcd,
                                output logic [5:0] blk, output logic ovf);
    int unsigned t;
    int unsigned p;
    if (v > 999999) begin
      bcd = 24'hEEEEEE;
      blk = '0;
      ovf = 1'b1;
    end else begin
      t = v;
      p = 1;
      bcd = '0;
      blk = '0;
      for (int i = 0; i < 6; i++) begin
        bcd[4*i +: 4] = 4'(t % 10);
        t = t / 10;
        blk[i] = (i != 0) && (v < p);
        p = p * 10;
      end
      ovf = 1'b0;
    end
  endfunction

  task automatic check_res(input int unsigned v, input string tag);
    logic [23:0] eb;
    logic [5:0]  ek;
    logic        eo;
    model(v, eb, ek, eo);
    chk({tag, "_bcd"}, 64'(bus.bcd_out), 64'(eb));
    chk({tag, "_blank"}, 64'(bus.blank), 64'(ek));
    chk({tag, "_ovf"}, 64'(bus.overflow), 64'(eo));
  endtask

  // Called right after the accepting edge; returns edges until done and busy samples seen.
  task automatic wait_done(input bit scramble, output int n, output int nbusy);
    n = 0;
    nbusy = 0;
    while (n < 40) begin
      if (bus.busy) nbusy++;
      tick();
      n++;
      if (bus.done) break;
      if (scramble) begin
        bus.bin_in = 20'($urandom);
        bus.start  = 1'b1;
      end
    end
    if (!bus.done) chk("done_timeout", 64'(bus.done), 64'd1);
  endtask

  task automatic convert(input int unsigned v, input string tag);
    int n;
    int nb;
    bus.start  = 1'b1;
    bus.bin_in = 20'(v);
    tick();
    bus.start  = 1'b0;
    bus.bin_in = 20'($urandom);
    wait_done(1'b0, n, nb);
    chk({tag, "_latency"}, 64'(n), 64'd20);
    chk({tag, "_busy_cycles"}, 64'(nb), 64'd20);
    chk({tag, "_busy_at_done"}, 64'(bus.busy), 64'd0);
    check_res(v, tag);
    tick();
    chk({tag, "_done_pulse"}, 64'(bus.done), 64'd0);
    check_res(v, {tag, "_held"});
  endtask

  initial begin
    int unsigned vals[4];
    int n;
    int nb;
    int ndone;

    rst        = 1'b1;
    bus.start  = 1'b0;
    bus.bin_in = '0;
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_bcd", 64'(bus.bcd_out), 64'd0);
    chk("rst_blank", 64'(bus.blank), 64'b111110);
    chk("rst_ovf", 64'(bus.overflow), 64'd0);

    convert(0, "zero");
    convert(123456, "v123456");
    convert(255, "v255");
    convert(999999, "v999999");
    convert(1000000, "v1000000");
    convert(20'hFFFFF, "vFFFFF");
    convert(9, "v9");
    convert(10, "v10");

    for (int i = 0; i < 24; i++) begin
      if (i % 2 == 0) convert($urandom_range(0, 20'hFFFFF), "rand_full");
      else            convert($urandom_range(0, 999999), "rand_fit");
    end

    // start held high through busy; only acceptance-edge values count
    for (int j = 0; j < 4; j++) vals[j] = $urandom_range(0, 20'hFFFFF);
    bus.start = 1'b1;
    for (int j = 0; j < 4; j++) begin
      bus.bin_in = 20'(vals[j]);
      tick();
      wait_done(1'b1, n, nb);
      chk("b2b_latency", 64'(n), 64'd20);
      check_res(vals[j], "b2b");
    end
    bus.start = 1'b0;
    tick();
    chk("b2b_done_low", 64'(bus.done), 64'd0);

    // abort a conversion with reset while start is also requested
    convert(42, "v42");
    bus.start  = 1'b1;
    bus.bin_in = 20'd777;
    tick();
    bus.start = 1'b0;
    repeat (9) tick();
    chk("abort_busy_before", 64'(bus.busy), 64'd1);
    rst        = 1'b1;
    bus.start  = 1'b1;
    bus.bin_in = 20'd999;
    tick();
    rst       = 1'b0;
    bus.start = 1'b0;
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_done", 64'(bus.done), 64'd0);
    chk("abort_bcd", 64'(bus.bcd_out), 64'd0);
    chk("abort_blank", 64'(bus.blank), 64'b111110);
    chk("abort_ovf", 64'(bus.overflow), 64'd0);
    ndone = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (bus.done) ndone++;
    end
    chk("abort_no_done", 64'(ndone), 64'd0);
    chk("abort_idle_busy", 64'(bus.busy), 64'd0);
    convert(5, "v5");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
